// File: rtl/paj7620_bus_sched.sv
// Arbitrates the PAJ7620 I2C controller between config writes (priority) and periodic gesture reads.
// Min 4 cycles per transaction; cfg_req is held until cfg_ack, polls collapse to one pending request.
module paj7620_bus_sched #(
   parameter int unsigned POLL_PERIOD = 1000,
   parameter int unsigned HOLD_CYCLES = 1000,
   parameter int unsigned TIMEOUT     = 4095,
   parameter logic [23:0] POLL_CMD    = 24'h00_43_00
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        cfg_req,
   input  logic [23:0] cfg_data,
   input  logic        cfg_last,
   output logic        cfg_ack,
   output logic        i2c_start,
   output logic [23:0] i2c_cmd,
   output logic        i2c_rd,
   input  logic        i2c_end,
   input  logic [7:0]  i2c_rdata,
   output logic        init_done,
   output logic [3:0]  gesture,
   output logic        gesture_vld,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

   localparam logic [19:0] POLL_TC = 20'(POLL_PERIOD - 1);
   localparam logic [25:0] HOLD_TC = 26'(HOLD_CYCLES - 1);
   localparam logic [11:0] TMO_TC  = 12'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;        // 1 = poller owns the bus
   logic        last_q, last_d;
   logic [23:0] cmd_q, cmd_d;
   logic        rd_q, rd_d;
   logic [3:0]  rdata_q, rdata_d;
   logic [11:0] tmo_q, tmo_d;
   logic        init_q, init_d;
   logic        err_q, err_d;
   logic [19:0] poll_cnt_q, poll_cnt_d;
   logic        pend_q, pend_d;
   logic [3:0]  gest_q, gest_d;
   logic        gvld_q, gvld_d;
   logic [25:0] hold_q, hold_d;

   logic        poll_tick;
   logic        onehot;
   logic        load;
   logic        unused_rdata_hi;

   assign unused_rdata_hi = ^i2c_rdata[7:4];

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      cmd_d      = cmd_q;
      rd_d       = rd_q;
      rdata_d    = rdata_q;
      tmo_d      = tmo_q;
      init_d     = init_q;
      err_d      = err_q;
      poll_cnt_d = poll_cnt_q;
      pend_d     = pend_q;
      gest_d     = gest_q;
      gvld_d     = 1'b0;
      hold_d     = hold_q;
      poll_tick  = 1'b0;

      if (init_q) begin
         if (poll_cnt_q == POLL_TC) begin
            poll_cnt_d = '0;
            poll_tick  = 1'b1;
         end else begin
            poll_cnt_d = poll_cnt_q + 20'd1;
         end
      end

      case (state_q)
         IDLE: begin
            if (cfg_req) begin
               owner_d = 1'b0;
               cmd_d   = cfg_data;
               rd_d    = 1'b0;
               last_d  = cfg_last;
               state_d = ISSUE;
            end else if (pend_q) begin
               owner_d = 1'b1;
               cmd_d   = POLL_CMD;
               rd_d    = 1'b1;
               last_d  = 1'b0;
               pend_d  = 1'b0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            tmo_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (i2c_end) begin
               rdata_d = i2c_rdata[3:0];
               state_d = FINISH;
            end else if (tmo_q == TMO_TC) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 12'd1;
            end
         end
         FINISH: begin
            if (!owner_q && last_q) init_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // a tick landing on a grant cycle starts a fresh request
      if (poll_tick) pend_d = 1'b1;

      onehot = (rdata_q != 4'd0) && ((rdata_q & (rdata_q - 4'd1)) == 4'd0);
      load   = (state_q == FINISH) && owner_q && onehot;

      if (load) begin
         gest_d = rdata_q;
         gvld_d = 1'b1;
         hold_d = '0;
      end else if (gest_q != 4'd0) begin
         if (hold_q == HOLD_TC) begin
            gest_d = 4'd0;
            hold_d = '0;
         end else begin
            hold_d = hold_q + 26'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b0;
         cmd_q      <= '0;
         rd_q       <= 1'b0;
         rdata_q    <= '0;
         tmo_q      <= '0;
         init_q     <= 1'b0;
         err_q      <= 1'b0;
         poll_cnt_q <= '0;
         pend_q     <= 1'b0;
         gest_q     <= '0;
         gvld_q     <= 1'b0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         cmd_q      <= cmd_d;
         rd_q       <= rd_d;
         rdata_q    <= rdata_d;
         tmo_q      <= tmo_d;
         init_q     <= init_d;
         err_q      <= err_d;
         poll_cnt_q <= poll_cnt_d;
         pend_q     <= pend_d;
         gest_q     <= gest_d;
         gvld_q     <= gvld_d;
         hold_q     <= hold_d;
      end
   end

   assign i2c_start   = (state_q == ISSUE);
   assign cfg_ack     = (state_q == FINISH) && !owner_q;
   assign i2c_cmd     = cmd_q;
   assign i2c_rd      = rd_q;
   assign init_done   = init_q;
   assign gesture     = gest_q;
   assign gesture_vld = gvld_q;
   assign bus_err     = err_q;

endmodule

// File: tb/tb_paj7620_bus_sched.sv
// Scoreboarded bench: stimulus pushes expected starts/gesture codes, a monitor pops them on DUT outputs.
// Controller model answers each start 10 cycles later unless muted.
module tb_paj7620_bus_sched;

   logic        sys_clk;
   logic        sys_rst;
   logic        cfg_req;
   logic [23:0] cfg_data;
   logic        cfg_last;
   logic        cfg_ack;
   logic        i2c_start;
   logic [23:0] i2c_cmd;
   logic        i2c_rd;
   logic        i2c_end;
   logic [7:0]  i2c_rdata;
   logic        init_done;
   logic [3:0]  gesture;
   logic        gesture_vld;
   logic        bus_err;

   paj7620_bus_sched #(
      .POLL_PERIOD(50),
      .HOLD_CYCLES(100),
      .TIMEOUT(20),
      .POLL_CMD(24'h00_43_00)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .cfg_req(cfg_req),
      .cfg_data(cfg_data),
      .cfg_last(cfg_last),
      .cfg_ack(cfg_ack),
      .i2c_start(i2c_start),
      .i2c_cmd(i2c_cmd),
      .i2c_rd(i2c_rd),
      .i2c_end(i2c_end),
      .i2c_rdata(i2c_rdata),
      .init_done(init_done),
      .gesture(gesture),
      .gesture_vld(gesture_vld),
      .bus_err(bus_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [7:0] rd;
      bit         vld;
      logic [3:0] g;
   } rsp_t;

   rsp_t        script_q[$];
   logic [23:0] exp_cfg_q[$];
   logic [3:0]  exp_gest_q[$];
   int          start_cyc_q[$];
   bit          start_rd_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int poll_starts = 0;
   int last_poll_cyc = 0;
   int rsp_cnt = 0;
   int ack_cnt = 0;
   bit have_prev = 0;
   bit per_chk = 0;
   bit mute = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // monitor: samples 1 time unit after each rising edge
   initial forever begin
      @(posedge sys_clk);
      #1;
      if (!sys_rst) begin
         if (i2c_start) begin
            start_cyc_q.push_back(cyc);
            start_rd_q.push_back(i2c_rd);
            if (!i2c_rd) begin
               if (exp_cfg_q.size() == 0) chk("cfg_start_unexpected", exp_cfg_q.size(), 1);
               else chk("cfg_cmd", {8'h00, i2c_cmd}, {8'h00, exp_cfg_q.pop_front()});
            end else begin
               chk("poll_cmd", {8'h00, i2c_cmd}, 32'h0000_4300);
               chk("poll_after_init", init_done, 1);
               if (per_chk && have_prev) chk("poll_period", cyc - last_poll_cyc, 50);
               have_prev     = 1;
               last_poll_cyc = cyc;
               poll_starts++;
            end
         end
         if (cfg_ack) ack_cnt++;
         if (gesture_vld) begin
            if (exp_gest_q.size() == 0) chk("gesture_vld_unexpected", exp_gest_q.size(), 1);
            else chk("gesture_code", gesture, exp_gest_q.pop_front());
         end
      end
   end

   // controller model
   initial begin : responder
      rsp_t r;
      bit   is_rd;
      i2c_end   = 1'b0;
      i2c_rdata = 8'h00;
      forever begin
         @(negedge sys_clk);
         if (i2c_start && !mute && !sys_rst) begin
            is_rd = i2c_rd;
            r     = '{8'h00, 1'b0, 4'h0};
            if (is_rd && script_q.size() > 0) r = script_q.pop_front();
            repeat (10) @(negedge sys_clk);
            i2c_rdata = is_rd ? r.rd : 8'h5A;
            if (is_rd) begin
               rsp_cnt++;
               if (r.vld) exp_gest_q.push_back(r.g);
            end
            i2c_end = 1'b1;
            @(negedge sys_clk);
            i2c_end = 1'b0;
         end
      end
   end

   task automatic cfg_write(input logic [23:0] d, input logic last);
      int g;
      exp_cfg_q.push_back(d);
      cfg_req  = 1'b1;
      cfg_data = d;
      cfg_last = last;
      g = 0;
      @(negedge sys_clk);
      while (!cfg_ack && g < 300) begin
         @(negedge sys_clk);
         g++;
      end
      chk("cfg_ack_seen", cfg_ack, 1);
      cfg_req  = 1'b0;
      cfg_last = 1'b0;
   endtask

   task automatic wait_gest(input logic [3:0] gv, input int lim, input string name);
      int n = 0;
      while (gesture !== gv && n < lim) begin
         @(negedge sys_clk);
         n++;
      end
      chk(name, gesture, gv);
   endtask

   task automatic wait_poll(input int n, input int lim);
      int g = 0;
      while (poll_starts == n && g < lim) begin
         @(negedge sys_clk);
         g++;
      end
      chk("poll_start_seen", poll_starts, n + 1);
   endtask

   initial begin : main
      int n;
      int m;
      sys_rst  = 1'b1;
      cfg_req  = 1'b0;
      cfg_data = 24'h0;
      cfg_last = 1'b0;
      script_q.push_back('{8'h04, 1'b1, 4'b0100});
      script_q.push_back('{8'h01, 1'b1, 4'b0001});
      script_q.push_back('{8'h00, 1'b0, 4'b0000});
      script_q.push_back('{8'h00, 1'b0, 4'b0000});
      script_q.push_back('{8'h08, 1'b1, 4'b1000});
      script_q.push_back('{8'h03, 1'b0, 4'b0000});
      script_q.push_back('{8'hF2, 1'b1, 4'b0010});

      repeat (3) @(negedge sys_clk);
      chk("rst_start", i2c_start, 0);
      chk("rst_cmd", {8'h00, i2c_cmd}, 0);
      chk("rst_rd", i2c_rd, 0);
      chk("rst_ack", cfg_ack, 0);
      chk("rst_init", init_done, 0);
      chk("rst_gesture", gesture, 0);
      chk("rst_gvld", gesture_vld, 0);
      chk("rst_err", bus_err, 0);
      sys_rst = 1'b0;
      per_chk = 1;
      repeat (2) @(negedge sys_clk);

      // configuration stream
      cfg_write(24'h00_EF_00, 1'b0);
      cfg_write(24'h01_32_29, 1'b0);
      cfg_write(24'h00_EF_01, 1'b1);
      chk("init_at_last_ack", init_done, 0);
      @(negedge sys_clk);
      chk("init_after_ack", init_done, 1);
      chk("ack_count", ack_cnt, 3);

      // polling, hold, invalid codes
      wait_gest(4'b0100, 400, "gesture_0100");
      wait_gest(4'b0001, 200, "gesture_0001");
      n = 0;
      while (gesture === 4'b0001 && n < 500) begin
         n++;
         @(negedge sys_clk);
      end
      chk("hold_len", n, 100);
      chk("hold_expired", gesture, 0);
      wait_gest(4'b1000, 200, "gesture_1000");
      n = rsp_cnt;
      m = 0;
      while (rsp_cnt == n && m < 100) begin
         @(negedge sys_clk);
         m++;
      end
      chk("invalid_read_done", rsp_cnt, n + 1);
      repeat (3) @(negedge sys_clk);
      chk("invalid_keeps", gesture, 4'b1000);
      wait_gest(4'b0010, 200, "gesture_f2");
      chk("script_consumed", script_q.size(), 0);

      // contention: second cfg request and pending poll meet in IDLE
      per_chk = 0;
      n = poll_starts;
      wait_poll(n, 100);
      repeat (40) @(negedge sys_clk);
      m = start_cyc_q.size();
      cfg_write(24'h00_12_34, 1'b0);
      cfg_write(24'h00_56_78, 1'b0);
      n = poll_starts;
      wait_poll(n, 100);
      chk("cont_count", start_rd_q.size(), m + 3);
      if (start_rd_q.size() >= m + 3) begin
         chk("cont_first_cfg", start_rd_q[m], 0);
         chk("cont_second_cfg", start_rd_q[m+1], 0);
         chk("cont_then_poll", start_rd_q[m+2], 1);
         chk("cont_cfg_gap", start_cyc_q[m+1] - start_cyc_q[m], 13);
         chk("cont_poll_gap", start_cyc_q[m+2] - start_cyc_q[m+1], 13);
      end

      // timeout
      repeat (15) @(negedge sys_clk);
      mute = 1;
      n = poll_starts;
      wait_poll(n, 100);
      repeat (20) @(negedge sys_clk);
      chk("bus_err_before_tmo", bus_err, 0);
      @(negedge sys_clk);
      chk("bus_err_set", bus_err, 1);
      mute = 0;
      cfg_write(24'h00_AB_CD, 1'b0);
      chk("bus_err_sticky", bus_err, 1);
      chk("init_sticky", init_done, 1);

      // reset in the middle of a WAIT
      mute = 1;
      exp_cfg_q.push_back(24'h00_DE_AD);
      cfg_req  = 1'b1;
      cfg_data = 24'h00_DE_AD;
      n = 0;
      while (!(i2c_start && !i2c_rd) && n < 200) begin
         @(negedge sys_clk);
         n++;
      end
      chk("rst_test_cfg_start", i2c_start, 1);
      repeat (5) @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      chk("arst_start", i2c_start, 0);
      chk("arst_cmd", {8'h00, i2c_cmd}, 0);
      chk("arst_ack", cfg_ack, 0);
      chk("arst_init", init_done, 0);
      chk("arst_err", bus_err, 0);
      chk("arst_gesture", gesture, 0);
      cfg_req = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("cfg_q_empty", exp_cfg_q.size(), 0);
      chk("gest_q_empty", exp_gest_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/paj7620_bus_sched.md
Name: paj7620_bus_sched

Overview:
- Owns the single I2C controller port to the PAJ7620 gesture sensor and grants it to two requesters:
  - the configuration sequencer (register-write stream), and
  - an internal periodic gesture poller (gesture-flag register read).
- Latches the gesture result, validates it as one-hot, and holds it for a programmable time so downstream LED/beep/seg logic sees a stable code.

Parameters:
- POLL_PERIOD, 1000, cycles between poll requests once init is done (counter width 20 bits).
- HOLD_CYCLES, 1000, cycles a valid gesture code stays asserted (counter width 26 bits).
- TIMEOUT, 4095, max cycles waiting for i2c_end before abort (12-bit counter).
- POLL_CMD, 24'h00_43_00, command word for a gesture read: bank 0, register 0x43, data don't-care.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous active-high reset.
- cfg_req  in  1  config sequencer requests a write; held until cfg_ack.
- cfg_data  in  24  write command word, stable while cfg_req is high.
- cfg_last  in  1  qualifies cfg_req: this is the final config write.
- cfg_ack  out  1  one-cycle pulse when a config transaction completes.
- i2c_start  out  1  one-cycle start pulse to the I2C controller.
- i2c_cmd  out  24  command word to the controller; held for the whole transaction.
- i2c_rd  out  1  1 = read transaction, 0 = write.
- i2c_end  in  1  one-cycle pulse from the controller when a transaction finishes.
- i2c_rdata  in  8  read data, valid in the i2c_end cycle.
- init_done  out  1  sticky high after the cfg_last transaction completes.
- gesture  out  4  held one-hot gesture code; 0 = none.
- gesture_vld  out  1  one-cycle pulse when gesture is loaded with a new code.
- bus_err  out  1  sticky high after any timeout; cleared only by reset.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- Arbitration happens in IDLE only, with fixed priority cfg over poll.
  - cfg_req high: select CFG owner, i2c_cmd = cfg_data, i2c_rd = 0, go to ISSUE.
  - Else if poll_pend: select POLL owner, i2c_cmd = POLL_CMD, i2c_rd = 1, clear poll_pend, go to ISSUE.
- ISSUE: i2c_start = 1 for exactly one cycle, then go to WAIT. Start to first possible i2c_end is at least 1 cycle.
- WAIT: tmo_cnt increments each cycle.
  - On i2c_end, go to FINISH.
  - If tmo_cnt reaches TIMEOUT-1 without i2c_end: set bus_err, go to IDLE. No cfg_ack; read data is discarded.
  - An i2c_end arriving outside WAIT is ignored.
- FINISH (1 cycle):
  - CFG owner: pulse cfg_ack; if cfg_last was high at grant, set init_done.
  - POLL owner: process the rdata latched at i2c_end.
  - Then go to IDLE. Minimum back-to-back cost is IDLE→ISSUE→WAIT(≥1)→FINISH = 4 cycles per transaction.
- Poll timer:
  - Runs only when init_done = 1.
  - Counts 0..POLL_PERIOD-1; at terminal count sets poll_pend and wraps to 0.
  - If poll_pend is already set, it stays set: no queueing, extra ticks are dropped.
- Gesture processing (POLL owner, in FINISH), on rdata[3:0]:
  - Exactly one bit set (0001/0010/0100/1000): gesture <= rdata[3:0], pulse gesture_vld, restart hold_cnt at 0. Applies even if the code equals the current one.
  - rdata[3:0] = 0000: no change; the current hold continues.
  - Multi-bit value: treated as invalid, no change.
  - rdata[7:4] is ignored.
- Hold timer:
  - While gesture != 0, hold_cnt increments.
  - At HOLD_CYCLES-1, gesture <= 0 and hold_cnt <= 0.
  - If a new valid code lands in the same cycle as expiry, the new code wins and the counter restarts.
- Asynchronous reset mid-transaction returns to IDLE immediately and clears init_done, bus_err and gesture. The controller must be reset by the same signal.

Test Plan:
- Reset then 3 cfg writes (last with cfg_last), controller answering i2c_end 10 cycles after start → 3 i2c_start pulses with i2c_rd=0 and matching cfg_data, 3 cfg_ack, init_done high 1 cycle after the third ack, no polls before init_done.
- Poll cycle: POLL_PERIOD=50, i2c_rdata=8'h04 → i2c_cmd=24'h004300 with i2c_rd=1 every 50 cycles, gesture=4'b0100, gesture_vld one pulse.
- Hold expiry: HOLD_CYCLES=100, one read 8'h01 then reads of 8'h00 → gesture=0001 for exactly 100 cycles, then 0; reads of 8'h00 do not extend the hold.
- Invalid code: rdata=8'h03 while gesture=1000 → gesture stays 1000, no gesture_vld; rdata=8'hF2 → gesture=0010.
- Contention: cfg_req and poll_pend both pending in IDLE → cfg served first, poll served immediately after, never both in one transaction.
- Timeout: no i2c_end, TIMEOUT=20 → bus_err rises 20 cycles into WAIT, FSM back to IDLE, next request is still served; assert sys_rst mid-WAIT → all outputs 0 on the same edge.
